regfile_wb_arbiter: RTL and testbench

- Shares the single RegisterFile write port (8 x 16-bit, 3-bit address) between two writeback requesters: A = ALU writeback (priority), B = load/multicycle-unit writeback.
- Registers the granted write onto RegWrite/write_register/write_data.
- Bypasses the in-flight write onto both read ports, because the RegisterFile only returns newly written data one cycle after the write edge.
- Sits between the writeback stage and the RegisterFile in the MIPS datapath.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/wb_starve_counter.sv | 38 +++
 rtl/regfile_wb_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register file widths and writeback request type
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_starve_counter.sv
// rtl/wb_starve_counter.sv - saturating count of consecutive blocked writeback cycles
module wb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // A zero limit never saturates, so the counter stays parked at zero.
    assign sat = (LIMIT != 0) && (cnt_q == LIMIT_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - arbitrates two writeback sources onto the register file write port
module regfile_wb_arbiter #(
    parameter int DATA_W        = regfile_pkg::DATA_W,
    parameter int ADDR_W        = regfile_pkg::ADDR_W,
    parameter int STARVE_LIMIT  = 4,
    parameter int ZERO_REG_LOCK = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write_register,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_register_1,
    input  logic [ADDR_W-1:0] read_register_2,
    input  logic [DATA_W-1:0] rf_read_data_1,
    input  logic [DATA_W-1:0] rf_read_data_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic              b_override
);

    logic              reg_write_q;
    logic              reg_write_d;
    logic [ADDR_W-1:0] write_register_q;
    logic [ADDR_W-1:0] write_register_d;
    logic [DATA_W-1:0] write_data_q;
    logic [DATA_W-1:0] write_data_d;

    logic              a_acc;
    logic              b_acc;
    logic              any_acc;
    logic [ADDR_W-1:0] grant_reg;
    logic [DATA_W-1:0] grant_data;
    logic              starve_inc;
    logic              starve_clr;

    wb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (starve_inc),
        .clr (starve_clr),
        .sat (b_override)
    );

    // The ready terms are mutually exclusive when both sides are valid,
    // so at most one handshake completes per cycle.
    always_comb begin
        a_ready    = ~rst & ~(b_override & b_valid);
        b_ready    = ~rst & (~a_valid | b_override);
        a_acc      = a_valid & a_ready;
        b_acc      = b_valid & b_ready;
        any_acc    = a_acc | b_acc;
        grant_reg  = b_acc ? b_reg  : a_reg;
        grant_data = b_acc ? b_data : a_data;
        starve_inc = b_valid & ~b_ready;
        starve_clr = b_acc | ~b_valid;
    end

    always_comb begin
        reg_write_d      = any_acc && !((ZERO_REG_LOCK != 0) && (grant_reg == '0));
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        if (any_acc) begin
            write_register_d = grant_reg;
            write_data_d     = grant_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            reg_write_q      <= reg_write_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
        end
    end

    assign RegWrite       = reg_write_q;
    assign write_register = write_register_q;
    assign write_data     = write_data_q;

    // The register file shows a write one cycle late; forward the in-flight one.
    always_comb begin
        read_data_1 = (reg_write_q && (write_register_q == read_register_1)) ? write_data_q : rf_read_data_1;
        read_data_2 = (reg_write_q && (write_register_q == read_register_2)) ? write_data_q : rf_read_data_2;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized model-checked bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    wb_req_t       a_req;
    wb_req_t       b_req;
    logic [2:0]    rr1;
    logic [2:0]    rr2;

    logic [15:0]   rf_m   [2][8];
    logic [15:0]   arch   [2][8];
    logic [15:0]   rfd1   [2];
    logic [15:0]   rfd2   [2];

    logic          ar [2];
    logic          br [2];
    logic          bo [2];
    logic          rw [2];
    logic [2:0]    wr [2];
    logic [15:0]   wd [2];
    logic [15:0]   rd1 [2];
    logic [15:0]   rd2 [2];

    int            cnt;
    logic          m_we [2];
    logic [2:0]    m_wr [2];
    logic [15:0]   m_wd [2];
    bit            chk_en;
    int            errors = 0;
    int            checks = 0;

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            rfd1[l] = rf_m[l][rr1];
            rfd2[l] = rf_m[l][rr2];
        end
    end

    regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(3), .STARVE_LIMIT(LIMIT), .ZERO_REG_LOCK(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .a_valid(a_req.valid), .a_ready(ar[0]), .a_reg(a_req.rd), .a_data(a_req.data),
        .b_valid(b_req.valid), .b_ready(br[0]), .b_reg(b_req.rd), .b_data(b_req.data),
        .RegWrite(rw[0]), .write_register(wr[0]), .write_data(wd[0]),
        .read_register_1(rr1), .read_register_2(rr2),
        .rf_read_data_1(rfd1[0]), .rf_read_data_2(rfd2[0]),
        .read_data_1(rd1[0]), .read_data_2(rd2[0]), .b_override(bo[0])
    );

    regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(3), .STARVE_LIMIT(LIMIT), .ZERO_REG_LOCK(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_valid(a_req.valid), .a_ready(ar[1]), .a_reg(a_req.rd), .a_data(a_req.data),
        .b_valid(b_req.valid), .b_ready(br[1]), .b_reg(b_req.rd), .b_data(b_req.data),
        .RegWrite(rw[1]), .write_register(wr[1]), .write_data(wd[1]),
        .read_register_1(rr1), .read_register_2(rr2),
        .rf_read_data_1(rfd1[1]), .rf_read_data_2(rfd2[1]),
        .read_data_1(rd1[1]), .read_data_2(rd2[1]), .b_override(bo[1])
    );

    task automatic chk(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, l, act, exp, $time);
        end
    endtask

    // One clock of the model: compare at the falling edge, then advance the
    // architectural state at the rising edge using the grant rules.
    task automatic step();
        bit      ovr, ear, ebr, acc_a, acc_b;
        wb_req_t g;
        @(negedge clk);
        ovr = (cnt == LIMIT);
        ear = !rst && !(ovr && b_req.valid);
        ebr = !rst && (!a_req.valid || ovr);
        if (chk_en) begin
            for (int l = 0; l < 2; l++) begin
                chk("a_ready", l, ar[l], ear);
                chk("b_ready", l, br[l], ebr);
                chk("b_override", l, bo[l], ovr);
                chk("RegWrite", l, rw[l], m_we[l]);
                chk("write_register", l, wr[l], m_wr[l]);
                chk("write_data", l, wd[l], m_wd[l]);
                chk("read_data_1", l, rd1[l], arch[l][rr1]);
                chk("read_data_2", l, rd2[l], arch[l][rr2]);
            end
        end
        acc_a = a_req.valid && ear;
        acc_b = b_req.valid && ebr;
        g = acc_b ? b_req : a_req;
        @(posedge clk);
        for (int l = 0; l < 2; l++) begin
            if (m_we[l]) rf_m[l][m_wr[l]] = m_wd[l];
            if (rst) begin
                m_we[l] = 1'b0;
                m_wr[l] = '0;
                m_wd[l] = '0;
            end else if (acc_a || acc_b) begin
                m_wr[l] = g.rd;
                m_wd[l] = g.data;
                m_we[l] = !(l == 1 && g.rd == 3'd0);
                if (m_we[l]) arch[l][g.rd] = g.data;
            end else begin
                m_we[l] = 1'b0;
            end
        end
        if (rst || acc_b || !b_req.valid) cnt = 0;
        else if (cnt < LIMIT) cnt++;
        #1;
        chk_en = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        a_req = '0;
        b_req = '0;
        rr1 = '0;
        rr2 = '0;
        cnt = 0;
        chk_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rf_m[0][i] = 16'($urandom);
            rf_m[1][i] = rf_m[0][i];
            arch[0][i] = rf_m[0][i];
            arch[1][i] = rf_m[0][i];
        end
        for (int l = 0; l < 2; l++) begin
            m_we[l] = 1'b0;
            m_wr[l] = '0;
            m_wd[l] = '0;
        end
        step();

        // Reset state, with both requesters asking
        a_req.valid = 1'b1;
        b_req.valid = 1'b1;
        #2;
        for (int l = 0; l < 2; l++) begin
            chk("rst RegWrite", l, rw[l], 0);
            chk("rst write_register", l, wr[l], 0);
            chk("rst write_data", l, wd[l], 0);
            chk("rst b_override", l, bo[l], 0);
            chk("rst a_ready", l, ar[l], 0);
            chk("rst b_ready", l, br[l], 0);
        end
        step();
        rst = 1'b0;
        a_req = '0;
        b_req = '0;
        step();

        // A only, then bypass and passthrough of reg 4
        a_req = '{1'b1, 3'd4, 16'd20};
        rr1 = 3'd4;
        step();
        a_req.valid = 1'b0;
        #2;
        chk("A-only RegWrite", 0, rw[0], 1);
        chk("A-only write_register", 0, wr[0], 4);
        chk("A-only write_data", 0, wd[0], 20);
        chk("A-only bypass", 0, rd1[0], 20);
        step();
        #2;
        chk("A-only idle RegWrite", 0, rw[0], 0);
        chk("A-only passthrough", 0, rd1[0], 20);
        step();

        // Contention until B is forced through
        a_req = '{1'b1, 3'd1, 16'h0abc};
        b_req = '{1'b1, 3'd2, 16'd7};
        for (int k = 1; k <= 6; k++) begin
            #2;
            for (int l = 0; l < 2; l++) begin
                if (k <= 4) begin
                    chk("starve b_ready", l, br[l], 0);
                    chk("starve b_override", l, bo[l], 0);
                end else if (k == 5) begin
                    chk("override b_override", l, bo[l], 1);
                    chk("override b_ready", l, br[l], 1);
                    chk("override a_ready", l, ar[l], 0);
                end else begin
                    chk("override write_register", l, wr[l], 2);
                    chk("override write_data", l, wd[l], 7);
                    chk("override cleared", l, bo[l], 0);
                end
            end
            step();
        end
        a_req.valid = 1'b0;
        b_req.valid = 1'b0;
        step();

        // Same-register race: A first, B last, B persists
        a_req = '{1'b1, 3'd3, 16'h1111};
        b_req = '{1'b1, 3'd3, 16'h2222};
        step();
        a_req.valid = 1'b0;
        #2;
        chk("race first data", 0, wd[0], 16'h1111);
        chk("race first reg", 0, wr[0], 3);
        step();
        b_req.valid = 1'b0;
        rr1 = 3'd3;
        #2;
        chk("race second data", 0, wd[0], 16'h2222);
        step();
        #2;
        chk("race final read", 0, rd1[0], 16'h2222);
        step();

        // Register 0 write with and without the lock
        b_req = '{1'b1, 3'd0, 16'h00ff};
        #2;
        chk("zero b_ready", 1, br[1], 1);
        step();
        b_req.valid = 1'b0;
        #2;
        chk("zero locked RegWrite", 1, rw[1], 0);
        chk("zero unlocked RegWrite", 0, rw[0], 1);
        chk("zero unlocked write_register", 0, wr[0], 0);
        step();

        // Reset in the middle of a contended stream
        a_req = '{1'b1, 3'd5, 16'habcd};
        b_req = '{1'b1, 3'd1, 16'h5555};
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        #2;
        for (int l = 0; l < 2; l++) begin
            chk("midrst a_ready", l, ar[l], 0);
            chk("midrst b_ready", l, br[l], 0);
            chk("midrst RegWrite before", l, rw[l], 1);
            chk("midrst write_register before", l, wr[l], 5);
        end
        step();
        rst = 1'b0;
        #2;
        for (int l = 0; l < 2; l++) begin
            chk("postrst RegWrite", l, rw[l], 0);
            chk("postrst b_override", l, bo[l], 0);
            chk("postrst a_ready", l, ar[l], 1);
        end
        step();
        #2;
        chk("resume RegWrite", 0, rw[0], 1);
        step();
        a_req.valid = 1'b0;
        b_req.valid = 1'b0;
        step();

        // Bypass miss on port 2
        a_req = '{1'b1, 3'd6, 16'h6666};
        rr2 = 3'd1;
        step();
        a_req.valid = 1'b0;
        #2;
        for (int l = 0; l < 2; l++) begin
            chk("miss RegWrite", l, rw[l], 1);
            chk("miss read_data_2", l, rd2[l], rf_m[l][1]);
        end
        step();

        // Randomized traffic with sticky B requests and occasional reset
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            a_req.valid = ($urandom_range(0, 3) != 0);
            a_req.rd = 3'($urandom);
            a_req.data = 16'($urandom);
            if (b_req.valid) b_req.valid = ($urandom_range(0, 7) != 0);
            else b_req.valid = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 3) == 0) begin
                b_req.rd = 3'($urandom);
                b_req.data = 16'($urandom);
            end
            rr1 = 3'($urandom);
            rr2 = 3'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
